uni_counter_nd: RTL
===================

Name: uni_counter_nd

Overview:
- Parametrised, cascadable multi-digit universal counter. Successor to the 4-bit single-digit universal counter.
- Counts in hex or decimal (BCD) per digit, up or down, with synchronous parallel load, pause and a carry-in enable.
- Provides a combinational carry/borrow-out for chaining instances and a registered wrap pulse for timers and event logic.
- Used as the timebase/display counter in downstream HW blocks.

Parameters:
NDIGITS, 2, number of 4-bit digits; legal range 1..8
DW, 4*NDIGITS, localparam (total count width, not overridable)

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset/clear; highest priority
data  input  DW  parallel load value, digit i at bits [4i+3:4i]
load  input  1  synchronous load of data when high
mode  input  1  1 = hex (radix 16 per digit), 0 = decimal (radix 10 per digit)
incr  input  1  1 = count up, 0 = count down
pause  input  1  1 = hold count
cin  input  1  count enable / carry-in from lower instance; tie 1 when standalone
count  output  DW  registered counter value
cout  output  1  combinational carry (up) / borrow (down) to next instance
wrap  output  1  registered one-cycle pulse following a full-counter wrap

Behaviour:
- Reset: clear=1 at posedge → count=0, wrap=0. Applies mid-count and overrides load/pause.
- Priority per posedge: clear > load > pause > count step.
- Step condition: step = cin & ~pause & ~load & ~clear. Otherwise count holds, except under clear or load.
- Load (no clear): count ← data; wrap ← 0.
  - In decimal mode, any loaded digit >9 is stored as 9.
  - In hex mode, data is stored unchanged.
- Digit radix R: 16 if mode=1, 10 if mode=0. MAX = R-1.
- Up step: digit 0 always steps. Digit i steps only when all lower digits are MAX (ripple carry).
  - A stepping digit at MAX → 0 and passes carry upward.
  - Decimal mode, digit >9 (mode switched after hex counting): treated as MAX, so → 0 with carry.
- Down step: digit 0 always steps. Digit i steps only when all lower digits are 0.
  - A stepping digit at 0 → MAX and passes borrow upward.
  - Decimal mode, digit >9 on down step: → 9, no borrow.
- Full-counter wrap: up from all-MAX → all-0; down from all-0 → all-MAX.
- cout = step & (incr ? all digits ≥ MAX : all digits == 0). Combinational, same cycle as the wrapping edge's inputs.
- wrap: registered version of cout. High exactly one cycle after the edge where the wrap occurred; 0 otherwise.
- mode and incr may change any cycle; they take effect on the next step with no pipeline.
- Cascading: lower.cout → upper.cin, shared clk/clear/mode/incr/pause. The chain behaves as one wider counter; no added latency, combinational cout path only.
- Latency: load/clear/step visible on count one cycle after the sampling edge.
- No X propagation: every register is defined under clear.

Decomposition:
- Package uni_counter_pkg holds:
  - constants HEX_MAX=4'hF and DEC_MAX=4'd9
  - MODE_HEX=1'b1, MODE_DEC=1'b0
  - function digit_max(mode)
- Sub-module uni_counter_digit (one instance per digit, generate loop):
  - inputs: clk, clear, load, ld_val, mode, incr, step_in
  - outputs: digit, carry_out (combinational: step_in & at-boundary)
  - Carry chain: step_in(0)=step; step_in(i+1)=carry_out(i); cout=carry_out(NDIGITS-1).
  - Load clamping for decimal lives in the digit cell.

Test Plan:
- Clear during counting: NDIGITS=2, decimal, up, count=37 → assert clear with load=1, pause=1 → count=00 and wrap=0 next cycle.
- Decimal up wrap: load 8'h98, mode=0, incr=1, cin=1 → 99, then 00. cout=1 in the cycle count=99; wrap=1 only in the cycle count=00.
- Hex down borrow: load 8'h10, mode=1, incr=0 → 0F, 0E. Then load 8'h00 → next FF, with cout=1 before the edge and wrap=1 one cycle after.
- Decimal clamp and mode switch: load 8'hAB with mode=0 → count=99. Separately, count=8'h0C in hex, switch mode=0, up step → 10. Down step from 0C in decimal → 09.
- Pause/cin hold: count=45 decimal, pause=1 for 3 cycles → 45, cout=0. Then pause=0, cin=0 → 45 held. Then cin=1 → 46.
- Cascade: two instances (NDIGITS=2) chained, decimal up from 0099 → 0100. Low instance cout=1 for exactly one cycle, and the high instance steps on that same edge.

Source files
------------

// File: rtl/uni_counter_pkg.sv
// rtl/uni_counter_pkg.sv - shared constants and helpers for the universal counter
package uni_counter_pkg;

  localparam logic [3:0] HEX_MAX  = 4'hF;
  localparam logic [3:0] DEC_MAX  = 4'd9;
  localparam logic       MODE_HEX = 1'b1;
  localparam logic       MODE_DEC = 1'b0;

  function automatic logic [3:0] digit_max(input logic mode);
    return (mode == MODE_HEX) ? HEX_MAX : DEC_MAX;
  endfunction

endpackage

// File: rtl/uni_counter_digit.sv
// rtl/uni_counter_digit.sv - one 4-bit hex/BCD digit cell with ripple carry/borrow
module uni_counter_digit
  import uni_counter_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       mode,
  input  logic       incr,
  input  logic       step_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] max_val;
  logic       at_max;
  logic       at_zero;
  logic       dec_over;

  assign max_val  = digit_max(mode);
  // A decimal digit above 9 (left over from hex counting) counts as MAX going up.
  assign at_max   = (digit >= max_val);
  assign at_zero  = (digit == 4'd0);
  assign dec_over = (mode == MODE_DEC) && (digit > DEC_MAX);

  assign carry_out = step_in & (incr ? at_max : at_zero);

  always_ff @(posedge clk) begin
    if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= ((mode == MODE_DEC) && (ld_val > DEC_MAX)) ? DEC_MAX : ld_val;
    end else if (step_in) begin
      if (incr) begin
        digit <= at_max ? 4'd0 : digit + 4'd1;
      end else if (dec_over) begin
        digit <= DEC_MAX;
      end else if (at_zero) begin
        digit <= max_val;
      end else begin
        digit <= digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/uni_counter_nd.sv
// rtl/uni_counter_nd.sv - cascadable multi-digit hex/decimal up/down counter
module uni_counter_nd
  import uni_counter_pkg::*;
#(
  parameter  int NDIGITS = 2,
  localparam int DW      = 4 * NDIGITS
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [DW-1:0] data,
  input  logic          load,
  input  logic          mode,
  input  logic          incr,
  input  logic          pause,
  input  logic          cin,
  output logic [DW-1:0] count,
  output logic          cout,
  output logic          wrap
);

  logic             step;
  logic [NDIGITS:0] carry;

  assign step     = cin & ~pause & ~load & ~clear;
  assign carry[0] = step;
  assign cout     = carry[NDIGITS];

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    uni_counter_digit u_digit (
      .clk       (clk),
      .clear     (clear),
      .load      (load),
      .ld_val    (data[4*i +: 4]),
      .mode      (mode),
      .incr      (incr),
      .step_in   (carry[i]),
      .digit     (count[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  // cout is already gated by step, so a load or pause edge leaves wrap low.
  always_ff @(posedge clk) begin
    if (clear) begin
      wrap <= 1'b0;
    end else begin
      wrap <= cout;
    end
  end

endmodule
